uart_fifo_controller: RTL and testbench

//  Next-generation UART top. Replaces the fixed 4-entry baud table with a runtime 16x-oversample

---
 rtl/uart_fifo_controller_if.sv | 35 +++
 rtl/uart_fifo_controller.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_fifo_controller.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_fifo_controller_if.sv
// Host-side bus of the UART FIFO controller.
//   master : host (pushes TX bytes, pops RX entries, clears overrun)
//   slave  : uart_fifo_controller
//   tx_wr_i/tx_wdata_i       TX FIFO push strobe and data
//   tx_full_o/tx_level_o     TX FIFO status, tx_idle_o: nothing queued or in flight
//   rx_rd_i                  RX FIFO pop strobe
//   rx_rdata_o/rx_rerr_o     RX head data and {stop_err, parity_err}
//   rx_empty_o/rx_level_o    RX FIFO status, rx_ovr_o sticky overrun, rx_ovr_clr_i clears it
interface uart_fifo_controller_if #(
  parameter int MAX_UART_DATA_W = 8,
  parameter int TX_DEPTH        = 16,
  parameter int RX_DEPTH        = 16
);
  logic                          tx_wr_i;
  logic [MAX_UART_DATA_W-1:0]    tx_wdata_i;
  logic                          tx_full_o;
  logic [$clog2(TX_DEPTH):0]     tx_level_o;
  logic                          tx_idle_o;
  logic                          rx_rd_i;
  logic [MAX_UART_DATA_W-1:0]    rx_rdata_o;
  logic [1:0]                    rx_rerr_o;
  logic                          rx_empty_o;
  logic [$clog2(RX_DEPTH):0]     rx_level_o;
  logic                          rx_ovr_o;
  logic                          rx_ovr_clr_i;

  modport master (
    output tx_wr_i, tx_wdata_i, rx_rd_i, rx_ovr_clr_i,
    input  tx_full_o, tx_level_o, tx_idle_o, rx_rdata_o, rx_rerr_o, rx_empty_o, rx_level_o, rx_ovr_o
  );
  modport slave (
    input  tx_wr_i, tx_wdata_i, rx_rd_i, rx_ovr_clr_i,
    output tx_full_o, tx_level_o, tx_idle_o, rx_rdata_o, rx_rerr_o, rx_empty_o, rx_level_o, rx_ovr_o
  );
endinterface

// File: rtl/uart_fifo_controller.sv
// UART with runtime 16x-oversample baud divisor, TX/RX FIFOs and an RX line synchroniser.
//   clk_i, rst_i            clock, synchronous active-high reset
//   baud_div_i              oversample tick period minus 1
//   tx_en_i, tx_conf_i      TX enable and per-character config {data[1:0], stop[1:0], parity_en}
//   uart_tx_o               serial TX line
//   rx_en_i, rx_conf_i      RX enable and config (static while a character is received)
//   uart_rx_i               asynchronous serial RX line
//   host                    FIFO push/pop/status bus (slave side)
// Config: data bits = 5 + data code, stop code 0 -> 1 stop bit else 2, parity_en -> even parity.
module uart_fifo_controller #(
  parameter int MAX_UART_DATA_W = 8,
  parameter int TOTAL_CONF_W    = 5,
  parameter int DIV_W           = 16,
  parameter int TX_DEPTH        = 16,
  parameter int RX_DEPTH        = 16,
  parameter int SYNC_STAGES     = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [DIV_W-1:0]        baud_div_i,
  input  logic                    tx_en_i,
  input  logic [TOTAL_CONF_W-1:0] tx_conf_i,
  output logic                    uart_tx_o,
  input  logic                    rx_en_i,
  input  logic [TOTAL_CONF_W-1:0] rx_conf_i,
  input  logic                    uart_rx_i,
  uart_fifo_controller_if.slave   host
);
  localparam int DW    = MAX_UART_DATA_W;
  localparam int TXA_W = $clog2(TX_DEPTH);
  localparam int RXA_W = $clog2(RX_DEPTH);
  localparam int FR_W  = DW + 4;              // start + data + parity + 2 stop
  localparam int BC_W  = $clog2(FR_W + 1);
  localparam logic [TXA_W:0] TX_FULL_LVL = (TXA_W+1)'(TX_DEPTH);
  localparam logic [RXA_W:0] RX_FULL_LVL = (RXA_W+1)'(RX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} tx_st_e;

  function automatic int dbits(input logic [TOTAL_CONF_W-1:0] c);
    return 5 + int'(c[4:3]);
  endfunction

  function automatic logic [BC_W-1:0] frame_len(input logic [TOTAL_CONF_W-1:0] c);
    return BC_W'(2 + dbits(c) + int'(c[0]) + int'(c[2:1] != 2'b00));
  endfunction

  // LSB-first frame, bits above the last stop bit are idle ones.
  function automatic logic [FR_W-1:0] build_frame(input logic [DW-1:0] d,
                                                  input logic [TOTAL_CONF_W-1:0] c);
    logic [FR_W-1:0] f;
    logic p;
    f = '1; f[0] = 1'b0; p = 1'b0;
    for (int i = 0; i < DW; i++)
      if (i < dbits(c)) begin f[i+1] = d[i]; p = p ^ d[i]; end
    if (c[0]) f[dbits(c)+1] = p;
    return f;
  endfunction

  // ---------------- baud tick ----------------
  logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
  logic baud_run, baud_tick;
  logic tx_busy_q, tx_busy_d, tx_done_q, tx_done_d;

  // A character already on the line keeps the counter alive so it can finish after tx_en_i drops.
  assign baud_run  = tx_en_i | rx_en_i | tx_busy_q;
  // >= rather than == so a divisor shrunk below the current count wraps at once.
  assign baud_tick = baud_run & (baud_cnt_q >= baud_div_i);

  always_comb begin
    baud_cnt_d = baud_cnt_q;
    if (baud_tick)     baud_cnt_d = '0;
    else if (baud_run) baud_cnt_d = baud_cnt_q + DIV_W'(1);
  end

  // ---------------- TX FIFO + launch FSM ----------------
  logic [DW-1:0]    tx_mem_q [TX_DEPTH];
  logic [TXA_W-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [TXA_W:0]   tx_lvl_q, tx_lvl_d;
  logic tx_push, tx_pop, tx_empty, tx_start;
  tx_st_e tx_st_q, tx_st_d;

  assign tx_empty        = tx_lvl_q == '0;
  assign host.tx_full_o  = tx_lvl_q == TX_FULL_LVL;
  assign host.tx_level_o = tx_lvl_q;
  assign host.tx_idle_o  = (tx_st_q == S_IDLE) & tx_empty & ~tx_busy_q;
  assign tx_push         = host.tx_wr_i & ~host.tx_full_o;
  assign tx_pop          = tx_start;

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_start = 1'b0;
    unique case (tx_st_q)
      S_IDLE:   if (!tx_empty && tx_en_i && !tx_busy_q) tx_st_d = S_LAUNCH;
      S_LAUNCH: begin tx_start = 1'b1; tx_st_d = S_WAIT; end
      // Shifter is already idle on the done cycle, so chain straight into the next launch.
      S_WAIT:   if (tx_done_q) tx_st_d = (!tx_empty && tx_en_i) ? S_LAUNCH : S_IDLE;
      default:  tx_st_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_wp_d  = tx_push ? tx_wp_q + TXA_W'(1) : tx_wp_q;
    tx_rp_d  = tx_pop  ? tx_rp_q + TXA_W'(1) : tx_rp_q;
    tx_lvl_d = tx_lvl_q;
    if (tx_push && !tx_pop)      tx_lvl_d = tx_lvl_q + (TXA_W+1)'(1);
    else if (!tx_push && tx_pop) tx_lvl_d = tx_lvl_q - (TXA_W+1)'(1);
  end

  // ---------------- TX shifter ----------------
  logic [FR_W-1:0] tx_fr_q, tx_fr_d;
  logic [BC_W-1:0] tx_bits_q, tx_bits_d;    // bits still to send after the current one
  logic [3:0]      tx_tk_q, tx_tk_d;

  always_comb begin
    tx_fr_d   = tx_fr_q;
    tx_bits_d = tx_bits_q;
    tx_tk_d   = tx_tk_q;
    tx_busy_d = tx_busy_q;
    tx_done_d = 1'b0;
    if (tx_start) begin
      tx_fr_d   = build_frame(tx_mem_q[tx_rp_q], tx_conf_i);
      tx_bits_d = frame_len(tx_conf_i) - BC_W'(1);
      tx_tk_d   = '0;
      tx_busy_d = 1'b1;
    end else if (tx_busy_q && baud_tick) begin
      tx_tk_d = tx_tk_q + 4'd1;
      if (tx_tk_q == 4'd15) begin
        if (tx_bits_q == '0) begin
          tx_busy_d = 1'b0;
          tx_done_d = 1'b1;
        end else begin
          tx_fr_d   = {1'b1, tx_fr_q[FR_W-1:1]};
          tx_bits_d = tx_bits_q - BC_W'(1);
        end
      end
    end
  end

  assign uart_tx_o = tx_busy_q ? tx_fr_q[0] : 1'b1;

  // ---------------- RX synchroniser + sampler ----------------
  logic [SYNC_STAGES-1:0] rx_sync_q, rx_sync_d;
  logic [FR_W-1:0] rx_fr_q, rx_fr_d;
  logic [BC_W-1:0] rx_idx_q, rx_idx_d;
  logic [3:0]      rx_tk_q, rx_tk_d;
  logic rx_busy_q, rx_busy_d, rx_done_q, rx_done_d, rx_s;

  assign rx_sync_d = {rx_sync_q[SYNC_STAGES-2:0], uart_rx_i};
  assign rx_s      = rx_sync_q[SYNC_STAGES-1];

  always_comb begin
    rx_fr_d   = rx_fr_q;
    rx_idx_d  = rx_idx_q;
    rx_tk_d   = rx_tk_q;
    rx_busy_d = rx_busy_q;
    rx_done_d = 1'b0;
    if (baud_tick) begin
      if (!rx_busy_q) begin
        if (rx_en_i && !rx_s) begin
          rx_busy_d = 1'b1;
          rx_tk_d   = '0;
          rx_idx_d  = '0;
        end
      end else begin
        rx_tk_d = rx_tk_q + 4'd1;
        if (rx_tk_q == 4'd7) begin                  // mid-bit sample
          rx_fr_d[rx_idx_q] = rx_s;
          rx_idx_d = rx_idx_q + BC_W'(1);
          if (rx_idx_q == '0 && rx_s) rx_busy_d = 1'b0;   // start bit did not hold: glitch
          // Finish at mid stop bit so the next start edge is not missed.
          else if (rx_idx_q == frame_len(rx_conf_i) - BC_W'(1)) begin
            rx_busy_d = 1'b0;
            rx_done_d = 1'b1;
          end
        end
      end
    end
  end

  logic [DW-1:0] rx_data;
  logic rx_par, rx_perr, rx_serr;

  always_comb begin
    rx_data = '0;
    rx_par  = 1'b0;
    for (int i = 0; i < DW; i++)
      if (i < dbits(rx_conf_i)) begin rx_data[i] = rx_fr_q[i+1]; rx_par = rx_par ^ rx_fr_q[i+1]; end
    rx_perr = rx_conf_i[0] & (rx_par ^ rx_fr_q[dbits(rx_conf_i)+1]);
    rx_serr = ~rx_fr_q[dbits(rx_conf_i) + 1 + int'(rx_conf_i[0])];
  end

  // ---------------- RX FIFO ----------------
  logic [DW+1:0]    rx_mem_q [RX_DEPTH];
  logic [RXA_W-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [RXA_W:0]   rx_lvl_q, rx_lvl_d;
  logic rx_push, rx_pop, rx_full, rx_ovr_q, rx_ovr_d;

  assign rx_full         = rx_lvl_q == RX_FULL_LVL;
  assign host.rx_empty_o = rx_lvl_q == '0;
  assign host.rx_level_o = rx_lvl_q;
  assign host.rx_ovr_o   = rx_ovr_q;
  assign host.rx_rdata_o = host.rx_empty_o ? '0 : rx_mem_q[rx_rp_q][DW-1:0];
  assign host.rx_rerr_o  = host.rx_empty_o ? '0 : rx_mem_q[rx_rp_q][DW+1:DW];
  assign rx_pop          = host.rx_rd_i & ~host.rx_empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the character.
  assign rx_push         = rx_done_q & (~rx_full | rx_pop);

  always_comb begin
    rx_wp_d  = rx_push ? rx_wp_q + RXA_W'(1) : rx_wp_q;
    rx_rp_d  = rx_pop  ? rx_rp_q + RXA_W'(1) : rx_rp_q;
    rx_lvl_d = rx_lvl_q;
    if (rx_push && !rx_pop)      rx_lvl_d = rx_lvl_q + (RXA_W+1)'(1);
    else if (!rx_push && rx_pop) rx_lvl_d = rx_lvl_q - (RXA_W+1)'(1);
    rx_ovr_d = (rx_ovr_q & ~host.rx_ovr_clr_i) | (rx_done_q & ~rx_push);   // set wins
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= host.tx_wdata_i;
    if (rx_push) rx_mem_q[rx_wp_q] <= {rx_serr, rx_perr, rx_data};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      baud_cnt_q <= '0;
      tx_wp_q <= '0; tx_rp_q <= '0; tx_lvl_q <= '0; tx_st_q <= S_IDLE;
      tx_fr_q <= '1; tx_bits_q <= '0; tx_tk_q <= '0; tx_busy_q <= 1'b0; tx_done_q <= 1'b0;
      rx_sync_q <= '1;
      rx_fr_q <= '1; rx_idx_q <= '0; rx_tk_q <= '0; rx_busy_q <= 1'b0; rx_done_q <= 1'b0;
      rx_wp_q <= '0; rx_rp_q <= '0; rx_lvl_q <= '0; rx_ovr_q <= 1'b0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      tx_wp_q <= tx_wp_d; tx_rp_q <= tx_rp_d; tx_lvl_q <= tx_lvl_d; tx_st_q <= tx_st_d;
      tx_fr_q <= tx_fr_d; tx_bits_q <= tx_bits_d; tx_tk_q <= tx_tk_d;
      tx_busy_q <= tx_busy_d; tx_done_q <= tx_done_d;
      rx_sync_q <= rx_sync_d;
      rx_fr_q <= rx_fr_d; rx_idx_q <= rx_idx_d; rx_tk_q <= rx_tk_d;
      rx_busy_q <= rx_busy_d; rx_done_q <= rx_done_d;
      rx_wp_q <= rx_wp_d; rx_rp_q <= rx_rp_d; rx_lvl_q <= rx_lvl_d; rx_ovr_q <= rx_ovr_d;
    end
  end
endmodule

// File: tb/tb_uart_fifo_controller.sv
// Directed bench for uart_fifo_controller: reset state, baud timing, TX framing,
// FIFO full/overrun, simultaneous push/pop at full, parity/stop errors, mid-frame reset.
module tb_uart_fifo_controller;
  localparam int DW = 8, TXD = 16, RXD = 16;
  localparam logic [4:0] C8N1 = 5'b11000, C8E1 = 5'b11001;

  logic clk_i = 1'b0, rst_i = 1'b1;
  logic [15:0] baud_div_i;
  logic tx_en_i, rx_en_i, uart_tx_o, uart_rx_i, loop, rx_drv;
  logic [4:0] tx_conf_i, rx_conf_i;
  int checks = 0, errors = 0;

  always #5 clk_i = ~clk_i;
  assign uart_rx_i = loop ? uart_tx_o : rx_drv;

  uart_fifo_controller_if #(.MAX_UART_DATA_W(DW), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) bus ();

  uart_fifo_controller #(.MAX_UART_DATA_W(DW), .TOTAL_CONF_W(5), .DIV_W(16),
                         .TX_DEPTH(TXD), .RX_DEPTH(RXD), .SYNC_STAGES(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .baud_div_i(baud_div_i),
    .tx_en_i(tx_en_i), .tx_conf_i(tx_conf_i), .uart_tx_o(uart_tx_o),
    .rx_en_i(rx_en_i), .rx_conf_i(rx_conf_i), .uart_rx_i(uart_rx_i),
    .host(bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic push(input logic [7:0] d);
    bus.tx_wr_i = 1'b1; bus.tx_wdata_i = d;
    cyc(1);
    bus.tx_wr_i = 1'b0;
  endtask

  task automatic pop();
    bus.rx_rd_i = 1'b1;
    cyc(1);
    bus.rx_rd_i = 1'b0;
  endtask

  // Counts negedges until uart_tx_o reaches lvl.
  task automatic wait_tx(input logic lvl, input int limit, output int n);
    n = 0;
    while (uart_tx_o !== lvl && n < limit) begin cyc(1); n++; end
    chk("tx_edge", uart_tx_o, lvl);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (bus.tx_idle_o !== 1'b1 && n < limit) begin cyc(1); n++; end
    chk("tx_idle_wait", bus.tx_idle_o, 1'b1);
  endtask

  // Decode one 8N1 frame off uart_tx_o by mid-bit sampling.
  task automatic mon(input int bclk, output logic [7:0] b, output logic stop);
    int n;
    wait_tx(1'b0, 20 * bclk, n);
    cyc(bclk / 2);
    for (int i = 0; i < 8; i++) begin cyc(bclk); b[i] = uart_tx_o; end
    cyc(bclk);
    stop = uart_tx_o;
  endtask

  // Drive an 8E1 frame on the RX pin, 16 clocks per bit (div=0).
  task automatic send_rx(input logic [7:0] d, input logic flip, input logic stop);
    logic [10:0] f;
    f = {stop, ^d ^ flip, d, 1'b0};
    for (int i = 0; i < 11; i++) begin rx_drv = f[i]; cyc(16); end
    rx_drv = 1'b1;
    cyc(48);
  endtask

  logic [7:0] exp_b [3];
  logic [7:0] b;
  logic stop;
  int n, t_cal;

  initial begin
    baud_div_i = '0; tx_en_i = 0; rx_en_i = 0; tx_conf_i = C8N1; rx_conf_i = C8N1;
    loop = 0; rx_drv = 1;
    bus.tx_wr_i = 0; bus.tx_wdata_i = '0; bus.rx_rd_i = 0; bus.rx_ovr_clr_i = 0;
    cyc(3); rst_i = 0; cyc(1);

    chk("rst_tx_full", bus.tx_full_o, 0);
    chk("rst_tx_level", bus.tx_level_o, 0);
    chk("rst_tx_idle", bus.tx_idle_o, 1);
    chk("rst_rx_empty", bus.rx_empty_o, 1);
    chk("rst_rx_level", bus.rx_level_o, 0);
    chk("rst_rx_ovr", bus.rx_ovr_o, 0);
    chk("rst_rx_rdata", bus.rx_rdata_o, 0);
    chk("rst_rx_rerr", bus.rx_rerr_o, 0);
    chk("rst_uart_tx", uart_tx_o, 1);

    // Baud: 0x55 toggles every bit; one bit = 16 ticks.
    baud_div_i = 16'd3; tx_en_i = 1;
    push(8'h55);
    wait_tx(1'b0, 2000, n); wait_tx(1'b1, 2000, n); wait_tx(1'b0, 2000, n);
    chk("bit_clks_div3", n, 64);
    wait_idle(2000);
    baud_div_i = 16'd0;
    push(8'h55);
    wait_tx(1'b0, 500, n); wait_tx(1'b1, 500, n); wait_tx(1'b0, 500, n);
    chk("bit_clks_div0", n, 16);
    wait_idle(500);

    // Three queued frames at div=26 (432 clocks per bit).
    tx_en_i = 0; baud_div_i = 16'd26;
    exp_b[0] = 8'h55; exp_b[1] = 8'hA3; exp_b[2] = 8'h0F;
    for (int k = 0; k < 3; k++) push(exp_b[k]);
    chk("tx_level3", bus.tx_level_o, 3);
    tx_en_i = 1;
    for (int k = 0; k < 3; k++) begin
      mon(432, b, stop);
      chk("tx_byte", b, exp_b[k]);
      chk("tx_stop", stop, 1);
    end
    chk("tx_busy_in_stop", bus.tx_idle_o, 0);
    wait_idle(1000);
    chk("tx_level0", bus.tx_level_o, 0);

    // TX overflow, then loopback into RX until it overruns.
    tx_en_i = 0; baud_div_i = 16'd0;
    for (int i = 0; i <= TXD; i++) push(8'(i));
    chk("tx_full", bus.tx_full_o, 1);
    chk("tx_level_full", bus.tx_level_o, TXD);
    loop = 1; rx_en_i = 1; tx_en_i = 1;
    wait_idle(TXD * 200);
    chk("rx_level_full", bus.rx_level_o, RXD);
    chk("rx_no_ovr_yet", bus.rx_ovr_o, 0);
    push(8'hEE);
    wait_idle(400);
    chk("rx_ovr_set", bus.rx_ovr_o, 1);
    chk("rx_level_ovr", bus.rx_level_o, RXD);
    bus.rx_ovr_clr_i = 1; cyc(1); bus.rx_ovr_clr_i = 0;
    chk("rx_ovr_clr", bus.rx_ovr_o, 0);
    for (int i = 0; i < RXD; i++) begin
      chk("rx_data", bus.rx_rdata_o, i);
      chk("rx_rerr0", bus.rx_rerr_o, 0);
      pop();
    end
    chk("rx_drained", bus.rx_empty_o, 1);
    chk("rx_drained_lvl", bus.rx_level_o, 0);

    // Measure TX start edge -> RX level change, then pop on the push cycle at full.
    push(8'h3C);
    wait_tx(1'b0, 200, n);
    t_cal = 0;
    while (bus.rx_level_o != 1 && t_cal < 400) begin cyc(1); t_cal++; end
    chk("rx_cal_level", bus.rx_level_o, 1);
    chk("rx_cal_head", bus.rx_rdata_o, 8'h3C);
    for (int i = 0; i < 15; i++) push(8'(8'h40 + i));
    wait_idle(16 * 200);
    chk("rx_full_again", bus.rx_level_o, RXD);
    push(8'hC3);
    wait_tx(1'b0, 200, n);
    cyc(t_cal - 1);
    pop();
    wait_idle(400);
    chk("pushpop_level", bus.rx_level_o, RXD);
    chk("pushpop_no_ovr", bus.rx_ovr_o, 0);
    chk("pushpop_head", bus.rx_rdata_o, 8'h40);
    for (int i = 0; i < 15; i++) pop();
    chk("pushpop_tail", bus.rx_rdata_o, 8'hC3);
    pop();
    chk("pushpop_empty", bus.rx_empty_o, 1);

    // Error status from a directly driven line, even parity.
    loop = 0; tx_en_i = 0; rx_conf_i = C8E1;
    send_rx(8'h07, 1'b0, 1'b1);
    chk("par_ok_data", bus.rx_rdata_o, 8'h07);
    chk("par_ok_rerr", bus.rx_rerr_o, 2'b00);
    pop();
    send_rx(8'h55, 1'b1, 1'b1);
    chk("par_err_data", bus.rx_rdata_o, 8'h55);
    chk("par_err_rerr", bus.rx_rerr_o, 2'b01);
    pop();
    send_rx(8'h55, 1'b0, 1'b0);
    chk("stop_err_rerr", bus.rx_rerr_o, 2'b10);
    chk("stop_err_data", bus.rx_rdata_o, 8'h55);

    // Reset while the start bit of a frame is on the line.
    for (int i = 0; i < 3; i++) push(8'(i * 8'h11));
    tx_en_i = 1;
    wait_tx(1'b0, 200, n);
    cyc(3);
    chk("pre_rst_tx_level", bus.tx_level_o, 2);
    chk("pre_rst_rx_empty", bus.rx_empty_o, 0);
    chk("pre_rst_line", uart_tx_o, 0);
    rst_i = 1; cyc(1);
    chk("mid_rst_line", uart_tx_o, 1);
    chk("mid_rst_tx_level", bus.tx_level_o, 0);
    chk("mid_rst_rx_level", bus.rx_level_o, 0);
    chk("mid_rst_rx_empty", bus.rx_empty_o, 1);
    chk("mid_rst_tx_idle", bus.tx_idle_o, 1);
    rst_i = 0; tx_en_i = 0; rx_en_i = 0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
